irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller directly upstream of the core's `interrupt_sig` input.
- Collects NUM_SRC asynchronous external lines and synchronises them.
- Latches edge-triggered events and applies per-source and global masks.
- Presents one prioritised request with a stable ID to the core, held under a req/ack/done handshake; no nesting.

Parameters:
- NUM_SRC, 4, number of interrupt sources; index 0 = highest priority.
- SYNC_STAGES, 2, flip-flops in each input synchroniser chain; minimum 2.
- ID_W, 2, width of irq_id; must satisfy 2**ID_W >= NUM_SRC.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- src_in  in  NUM_SRC  raw asynchronous interrupt lines.
- edge_mode  in  NUM_SRC  per source: 1 = rising-edge latched, 0 = level.
- src_en  in  NUM_SRC  per-source enable mask.
- global_en  in  1  master enable.
- irq_ack  in  1  core accepts the current request; single-cycle pulse.
- irq_done  in  1  core finished the handler (EOI); single-cycle pulse.
- irq_req  out  1  request to the core; drives interrupt_sig.
- irq_id  out  ID_W  source index of the current request or service.
- pending  out  NUM_SRC  registered pending vector, unmasked.
- in_service  out  1  high while the core is in a handler.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All sync flops, edge-history flops and pending bits are cleared.
  - irq_req=0, irq_id=0, pending=0, in_service=0.
- Synchroniser: src_in passes through SYNC_STAGES flops giving s_sync; a further flop gives s_prev.
  - Because s_prev resets to 0, a source held high through reset release registers as one rising edge.
- Pending bit i:
  - Edge mode: set on the clock after s_sync=1 and s_prev=0. Cleared when irq_ack is taken while irq_id=i. If set and clear occur in the same cycle, set wins.
  - Level mode: pending[i] follows s_sync[i] registered one cycle; irq_ack has no effect on it.
  - Changing edge_mode of a source takes effect next cycle; the current pending bit is kept.
- Eligible vector: pending & src_en, gated by global_en.
- Winner: the lowest eligible index.
- Latency: src_in rising to irq_req high takes SYNC_STAGES+2 rising clk edges (4 with defaults), provided the FSM is IDLE.
- FSM states:
  - IDLE: irq_req=0, in_service=0. If any source is eligible, latch irq_id = winner and go to REQ. irq_ack and irq_done are ignored.
  - REQ: irq_req=1; irq_id is frozen. No withdrawal: if the source deasserts or is masked, the request stays until acked. On irq_ack, clear the edge-mode pending bit and go to SERVICE next cycle.
  - SERVICE: irq_req=0, in_service=1, irq_id held. New events still set pending bits but raise no request. On irq_done, go to IDLE. irq_ack is ignored.
- Simultaneous irq_ack and irq_done in REQ: ack is taken, done is ignored.
- Re-arbitration:
  - After a return to IDLE, earliest re-request is irq_req high 2 edges after irq_done sampled.
  - A still-asserted level source re-requests immediately; the handler is responsible for clearing it at the device.
- irq_id is only meaningful while irq_req or in_service is high; otherwise it holds its last value.
- Reset mid-operation: immediate return to the reset state. Any in-flight request or service is lost without an ack.

Decomposition:
- Package irq_pkg holds:
  - State encoding localparams ST_IDLE=2'd0, ST_REQ=2'd1, ST_SVC=2'd2.
  - A priority-encode function (lowest set index) parameterised by NUM_SRC and ID_W.
- Sub-module irq_sync, one instance per source: SYNC_STAGES-deep synchroniser plus s_prev flop and rise output; async active-low reset.
- Top level holds the pending register, masking, arbitration and FSM.

Test Plan:
- Reset with src_in[2]=1 held, edge_mode=0, src_en=4'hF, global_en=1, then release → irq_req rises on edge 4 after release with irq_id=2.
- Edge source 1 pulsed high for 1 cycle → pending[1]=1 → irq_req=1, irq_id=1. Ack → pending[1]=0, in_service=1. irq_done → IDLE and no further request.
- Sources 3 and 0 rise in the same cycle, both edge mode → first request irq_id=0. After ack/done, second request irq_id=3 arrives 2 edges after done.
- src_en[1]=0 with source 1 edge pending → no irq_req, pending[1] stays 1. Set src_en[1]=1 → irq_req within 2 edges with irq_id=1.
- In SERVICE with id 2, source 2 edge arrives again → pending[2]=1, irq_req stays 0. After irq_done → new request with irq_id=2.
- rst pulled low while in REQ → irq_req, pending and in_service all drop to 0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_pkg.sv
// Purpose : shared FSM state encoding and priority encoder for the interrupt controller.
// Latency : n/a (types and a combinational helper only).
// Backpressure: n/a.
package irq_pkg;

    // Controller states: waiting, requesting the core, core inside a handler.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } irq_state_t;

    // Widest source vector the priority encoder accepts. Callers zero-extend
    // their vector to this width and pass their real source count.
    localparam int PRIO_MAX_SRC = 32;

    // Lowest set index among the first num_src bits of vec; 0 when none set.
    // Scanning from the top down lets the lowest index overwrite the result,
    // which keeps index 0 the highest priority without a break statement.
    function automatic int prio_enc(input logic [PRIO_MAX_SRC-1:0] vec,
                                    input int                      num_src);
        int idx;
        idx = 0;
        for (int i = PRIO_MAX_SRC - 1; i >= 0; i--) begin
            if ((i < num_src) && vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Purpose : one-bit synchroniser for an asynchronous interrupt line plus rising-edge detect.
// Latency : SYNC_STAGES clk edges to s_sync, rise valid in the same cycle as the new s_sync.
// Backpressure: none; free-running.
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset
//   d      raw asynchronous input line
//   s_sync synchronised level (last stage of the chain)
//   rise   s_sync high while the previous sampled value was low
module irq_sync #(
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   s_prev;

    // s_prev clears on reset, so a line already high when reset releases is
    // seen as a fresh rising edge once it emerges from the chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain  <= '0;
            s_prev <= 1'b0;
        end else begin
            chain  <= {chain[SYNC_STAGES-2:0], d};
            s_prev <= chain[SYNC_STAGES-1];
        end
    end

    assign s_sync = chain[SYNC_STAGES-1];
    assign rise   = s_sync & ~s_prev;

endmodule

// File: rtl/irq_ctrl.sv
// Purpose : synchronise, latch, mask and prioritise NUM_SRC interrupt lines into one core request.
// Latency : src_in rise to irq_req high in SYNC_STAGES+2 clk edges when idle; re-request 2 edges after irq_done.
// Backpressure: request held (never withdrawn) until irq_ack; no new request until irq_done.
//
// Ports:
//   clk, rst    clock and asynchronous active-low reset
//   src_in      raw asynchronous interrupt lines
//   edge_mode   per source: 1 = rising-edge latched, 0 = level
//   src_en      per-source enable mask
//   global_en   master enable
//   irq_ack     core accepts the current request (pulse)
//   irq_done    core finished its handler (pulse)
//   irq_req     request to the core
//   irq_id      source index of the current request / service
//   pending     registered pending vector before masking
//   in_service  core is inside a handler
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2,  // must be >= 2
    parameter int ID_W        = 2   // 2**ID_W must cover NUM_SRC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic [NUM_SRC-1:0] edge_mode,
    input  logic [NUM_SRC-1:0] src_en,
    input  logic               global_en,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               in_service
);

    logic [NUM_SRC-1:0] s_sync;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] pend_nxt;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    id_nxt;
    logic               ack_take;
    irq_state_t         state;
    irq_state_t         state_nxt;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        irq_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .rst    (rst),
            .d      (src_in[g]),
            .s_sync (s_sync[g]),
            .rise   (rise[g])
        );
    end

    // ------------------------------------------------------------------
    // Pending register
    // ------------------------------------------------------------------
    // An ack only counts while a request is actually outstanding; stray
    // acks in IDLE or SERVICE must not clear anything.
    assign ack_take = (state == ST_REQ) && irq_ack;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_clr
        assign ack_clr[g] = ack_take && (id_q == ID_W'(g));
    end

    // Edge sources: a new rise beats a same-cycle ack clear.
    // Level sources simply track the synchronised line one cycle later.
    assign pend_nxt = (edge_mode  & (rise | (pend_q & ~ack_clr)))
                    | (~edge_mode & s_sync);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Masking and arbitration
    // ------------------------------------------------------------------
    assign eligible = global_en ? (pend_q & src_en) : '0;
    assign winner   = ID_W'(prio_enc(PRIO_MAX_SRC'(eligible), NUM_SRC));

    // ------------------------------------------------------------------
    // Request / service FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            id_q  <= '0;
        end else begin
            state <= state_nxt;
            id_q  <= id_nxt;
        end
    end

    // irq_id is latched only on the IDLE->REQ transition so it stays
    // stable through the whole request and the following service.
    always_comb begin
        state_nxt  = state;
        id_nxt     = id_q;
        irq_req    = 1'b0;
        in_service = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|eligible) begin
                    state_nxt = ST_REQ;
                    id_nxt    = winner;
                end
            end
            ST_REQ: begin
                // Held even if the source drops or gets masked; only the
                // core's ack retires it. A coincident done is ignored.
                irq_req = 1'b1;
                if (irq_ack) begin
                    state_nxt = ST_SVC;
                end
            end
            ST_SVC: begin
                in_service = 1'b1;
                if (irq_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign irq_id  = id_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Purpose : self-checking bench for irq_ctrl: directed scenarios plus randomized traffic vs a reference model.
// Latency : n/a.
// Backpressure: bench plays the core, acking and finishing handlers at random.
module tb_irq_ctrl;

    localparam int N    = 4;
    localparam int S    = 2;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_in;
    logic [N-1:0]    edge_mode;
    logic [N-1:0]    src_en;
    logic            global_en;
    logic            irq_ack;
    logic            irq_done;
    logic            irq_req;
    logic [ID_W-1:0] irq_id;
    logic [N-1:0]    pending;
    logic            in_service;

    int errs   = 0;
    int checks = 0;

    irq_ctrl #(
        .NUM_SRC     (N),
        .SYNC_STAGES (S),
        .ID_W        (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_in     (src_in),
        .edge_mode  (edge_mode),
        .src_en     (src_en),
        .global_en  (global_en),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: raw samples travel through a queue of length S,
    // the controller is a small "phase" number (0 idle, 1 requesting,
    // 2 in handler).
    // ------------------------------------------------------------------
    logic [N-1:0] samp[$];
    logic [N-1:0] m_prev;
    logic [N-1:0] m_pend;
    int           m_phase;
    int           m_id;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        samp.delete();
        for (int k = 0; k < S; k++) samp.push_back('0);
        m_prev  = '0;
        m_pend  = '0;
        m_phase = 0;
        m_id    = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] seen;
        logic [N-1:0] newp;
        logic [N-1:0] elig;
        bit           take;
        if (!rst) begin
            model_reset();
            return;
        end
        seen = samp[S-1];
        elig = global_en ? (m_pend & src_en) : '0;
        take = (m_phase == 1) && irq_ack;
        for (int i = 0; i < N; i++) begin
            if (edge_mode[i])
                newp[i] = (seen[i] && !m_prev[i]) || (m_pend[i] && !(take && m_id == i));
            else
                newp[i] = seen[i];
        end
        if (m_phase == 0 && elig != '0) begin
            for (int i = 0; i < N; i++) begin
                if (elig[i]) begin
                    m_id = i;
                    break;
                end
            end
            m_phase = 1;
        end else if (m_phase == 1 && irq_ack) begin
            m_phase = 2;
        end else if (m_phase == 2 && irq_done) begin
            m_phase = 0;
        end
        m_pend = newp;
        m_prev = seen;
        samp.push_front(src_in);
        void'(samp.pop_back());
    endtask

    task automatic compare_all();
        chk("req",     32'(irq_req),    32'(m_phase == 1));
        chk("svc",     32'(in_service), 32'(m_phase == 2));
        chk("id",      32'(irq_id),     32'(m_id));
        chk("pending", 32'(pending),    32'(m_pend));
    endtask

    // One clock: model follows the same edge, outputs compared mid-cycle.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_req(output int n);
        n = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (irq_req) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic pulse_src(input int i);
        src_in[i] = 1'b1;
        cycle();
        src_in[i] = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        cycle();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1;
        cycle();
        irq_done = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, "_req"},  32'(irq_req),    32'd0);
        chk({tag, "_pend"}, 32'(pending),    32'd0);
        chk({tag, "_svc"},  32'(in_service), 32'd0);
        model_reset();
    endtask

    int n;

    initial begin
        rst       = 1'b0;
        src_in    = 4'b0100;
        edge_mode = 4'b0000;
        src_en    = 4'hF;
        global_en = 1'b1;
        irq_ack   = 1'b0;
        irq_done  = 1'b0;
        model_reset();
        #1;
        chk("rst_req", 32'(irq_req),    32'd0);
        chk("rst_id",  32'(irq_id),     32'd0);
        chk("rst_pend",32'(pending),    32'd0);
        chk("rst_svc", 32'(in_service), 32'd0);
        cycle();
        cycle();

        // Level source held through reset release: request on edge 4.
        rst = 1'b1;
        wait_req(n);
        chk("lat_reset", 32'(n), 32'd4);
        chk("lat_id",    32'(irq_id), 32'd2);
        pulse_ack();
        chk("lvl_pend_after_ack", 32'(pending[2]), 32'd1);
        src_in = '0;
        repeat (4) cycle();
        pulse_done();
        repeat (3) cycle();

        // Single edge on source 1.
        edge_mode = 4'hF;
        pulse_src(1);
        wait_req(n);
        chk("e1_id",   32'(irq_id),     32'd1);
        chk("e1_pend", 32'(pending[1]), 32'd1);
        pulse_ack();
        chk("e1_clr",  32'(pending[1]), 32'd0);
        chk("e1_svc",  32'(in_service), 32'd1);
        pulse_done();
        repeat (6) cycle();
        chk("e1_quiet", 32'(irq_req), 32'd0);

        // Sources 0 and 3 together: 0 first, 3 two edges after done.
        src_in = 4'b1001;
        cycle();
        src_in = '0;
        wait_req(n);
        chk("pr_first", 32'(irq_id), 32'd0);
        pulse_ack();
        pulse_done();
        wait_req(n);
        chk("pr_rearb_lat", 32'(n + 1), 32'd2);
        chk("pr_second",    32'(irq_id), 32'd3);
        pulse_ack();
        pulse_done();
        repeat (3) cycle();

        // Masked source stays pending, requests once enabled.
        src_en = 4'b1101;
        pulse_src(1);
        repeat (6) cycle();
        chk("mask_req",  32'(irq_req),    32'd0);
        chk("mask_pend", 32'(pending[1]), 32'd1);
        src_en = 4'hF;
        wait_req(n);
        chk("unmask_lat", 32'(n >= 1 && n <= 2), 32'd1);
        chk("unmask_id",  32'(irq_id), 32'd1);
        pulse_ack();
        pulse_done();
        repeat (3) cycle();

        // New event during service waits for done.
        pulse_src(2);
        wait_req(n);
        pulse_ack();
        pulse_src(2);
        repeat (5) cycle();
        chk("svc_pend", 32'(pending[2]), 32'd1);
        chk("svc_noreq",32'(irq_req),    32'd0);
        chk("svc_in",   32'(in_service), 32'd1);
        pulse_done();
        wait_req(n);
        chk("svc_rereq_lat", 32'(n + 1), 32'd2);
        chk("svc_rereq_id",  32'(irq_id), 32'd2);

        // Reset while requesting: outputs drop without a clock edge.
        @(negedge clk);
        async_reset_check("areset");
        cycle();
        rst = 1'b1;
        repeat (3) cycle();

        // Randomized traffic; bench acts as the core.
        for (int it = 0; it < 2000; it++) begin
            if ($urandom % 250 == 0) begin
                async_reset_check("rnd_rst");
                cycle();
                rst = 1'b1;
            end
            if ($urandom % 4 == 0)  src_in    = N'($urandom);
            if ($urandom % 40 == 0) edge_mode = N'($urandom);
            if ($urandom % 25 == 0) src_en    = N'($urandom);
            if ($urandom % 30 == 0) global_en = ($urandom % 8) != 0;
            irq_ack  = (m_phase == 1) ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
            irq_done = (m_phase == 2) ? ($urandom % 4 == 0) : ($urandom % 10 == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
